// File: rtl/iir_pkg.sv
// Shared types, saturation limits and sign-magnitude arithmetic for the biquad sequencer.
// Pure declarations: no latency and no handshake of its own.
package iir_pkg;

  localparam int IIR_W    = 16;
  localparam int IIR_FRAC = 8;

  typedef logic [IIR_W-1:0] sample_t;

  localparam sample_t SAT_POS = {1'b0, {(IIR_W-1){1'b1}}};
  localparam sample_t SAT_NEG = {1'b1, {(IIR_W-1){1'b1}}};

  typedef enum logic [2:0] {TAP_B0, TAP_B1, TAP_B2, TAP_A1, TAP_A2} tap_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_e;

  // Negative zero on either input behaves as +0; a zero result is always +0.
  function automatic sample_t sm_add(input sample_t a, input sample_t b);
    logic [IIR_W-2:0] ma;
    logic [IIR_W-2:0] mb;
    logic [IIR_W-2:0] mr;
    logic [IIR_W-1:0] sum;
    logic             sa;
    logic             sb;
    logic             sr;
    ma  = a[IIR_W-2:0];
    mb  = b[IIR_W-2:0];
    sa  = a[IIR_W-1] & (ma != '0);
    sb  = b[IIR_W-1] & (mb != '0);
    sum = {1'b0, ma} + {1'b0, mb};
    if (sa == sb) begin
      sr = sa;
      mr = sum[IIR_W-1] ? {(IIR_W-1){1'b1}} : sum[IIR_W-2:0];
    end else if (ma >= mb) begin
      sr = sa;
      mr = ma - mb;
    end else begin
      sr = sb;
      mr = mb - ma;
    end
    if (mr == '0) sr = 1'b0;
    return {sr, mr};
  endfunction

endpackage

// File: rtl/multiply.sv
// Unsigned fixed-point magnitude multiply, (a*b)>>FRAC truncated, saturating to all-ones.
// Combinational, zero latency; no handshake.
module multiply #(
  parameter int MW   = 15,
  parameter int FRAC = 8
) (
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  output logic [MW-1:0] p
);

  logic [2*MW-1:0] full;
  logic [2*MW-1:0] shifted;

  assign full    = {{MW{1'b0}}, a} * {{MW{1'b0}}, b};
  assign shifted = full >> FRAC;
  assign p       = (|shifted[2*MW-1:MW]) ? {MW{1'b1}} : shifted[MW-1:0];

endmodule

// File: rtl/iir_biquad_sequencer.sv
// Biquad IIR section with one shared multiplier, five taps per sample; latency 5 cycles accept->out_valid.
// out_ready low holds out_data and history and keeps in_ready low; config writes/clear are only taken in IDLE.
module iir_biquad_sequencer import iir_pkg::*; #(
  parameter int W    = IIR_W,
  parameter int FRAC = IIR_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         coef_we,
  input  logic [2:0]   coef_addr,
  input  logic [W-1:0] coef_data,
  input  logic         clear,
  output logic         cfg_err
);

  state_e       state;
  tap_e         tap;
  logic [W-1:0] coef [0:4];
  logic [W-1:0] xCur;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] acc;
  logic         cfgErr;

  logic [W-1:0] opCoef;
  logic [W-1:0] opData;
  logic         negate;
  logic [W-2:0] prodMag;
  logic [W-1:0] tapProd;
  logic [W-1:0] accNext;

  always_comb begin
    opCoef = coef[0];
    opData = xCur;
    negate = 1'b0;
    case (tap)
      TAP_B0: begin opCoef = coef[0]; opData = xCur; end
      TAP_B1: begin opCoef = coef[1]; opData = x1;   end
      TAP_B2: begin opCoef = coef[2]; opData = x2;   end
      TAP_A1: begin opCoef = coef[3]; opData = y1; negate = 1'b1; end
      TAP_A2: begin opCoef = coef[4]; opData = y2; negate = 1'b1; end
      default: ;
    endcase
  end

  multiply #(.MW(W-1), .FRAC(FRAC)) uMul (
    .a(opCoef[W-2:0]),
    .b(opData[W-2:0]),
    .p(prodMag)
  );

  // Feedback taps are subtracted by flipping the product sign.
  assign tapProd = {opCoef[W-1] ^ opData[W-1] ^ negate, prodMag};
  assign accNext = sm_add(acc, tapProd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      tap    <= TAP_B0;
      xCur   <= '0;
      x1     <= '0;
      x2     <= '0;
      y1     <= '0;
      y2     <= '0;
      acc    <= '0;
      cfgErr <= 1'b0;
      for (int i = 0; i < 5; i++) coef[i] <= '0;
    end else begin
      cfgErr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coef_we) begin
            case (coef_addr)
              3'd0: coef[0] <= coef_data;
              3'd1: coef[1] <= coef_data;
              3'd2: coef[2] <= coef_data;
              3'd3: coef[3] <= coef_data;
              3'd4: coef[4] <= coef_data;
              default: ;
            endcase
          end
          if (clear) begin
            x1 <= '0;
            x2 <= '0;
            y1 <= '0;
            y2 <= '0;
          end
          if (in_valid) begin
            xCur  <= in_data;
            acc   <= '0;
            tap   <= TAP_B0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          cfgErr <= coef_we | clear;
          acc    <= accNext;
          if (tap == TAP_A2) state <= ST_OUT;
          else               tap   <= tap_e'(tap + 3'd1);
        end
        ST_OUT: begin
          cfgErr <= coef_we | clear;
          if (out_ready) begin
            x2    <= x1;
            x1    <= xCur;
            y2    <= y1;
            y1    <= acc;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign out_data  = acc;
  assign cfg_err   = cfgErr;

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Scoreboarded bench for iir_biquad_sequencer: directed samples push expected outputs, a monitor pops on handshake.
// Inputs change only 1 time unit after a rising edge; the monitor samples on falling edges.
module tb_iir_biquad_sequencer;

  typedef struct {
    logic [15:0] val;
    int          acc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        clear;
  logic        cfg_err;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cfgCnt = 0;
  bit   seenValid = 1'b0;

  iir_biquad_sequencer #(.W(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .clear(clear), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chkInt(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cfg_err) cfgCnt++;
    if (!rst_n) begin
      seenValid = 1'b0;
    end else if (out_valid) begin
      if (!seenValid && expQ.size() != 0) begin
        seenValid = 1'b1;
        chkInt({expQ[0].name, "_latency"}, cyc - expQ[0].acc, 5);
      end
      if (out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          monE = expQ.pop_front();
          chk(monE.name, out_data, monE.val);
        end
        seenValid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("idle_wait_timeout", {15'd0, in_ready}, 16'd1);
  endtask

  task automatic wrCoef(input logic [2:0] a, input logic [15:0] d);
    waitIdle();
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic setCoefs(input logic [15:0] b0, b1, b2, a1, a2);
    wrCoef(3'd0, b0);
    wrCoef(3'd1, b1);
    wrCoef(3'd2, b2);
    wrCoef(3'd3, a1);
    wrCoef(3'd4, a2);
  endtask

  task automatic doClear();
    waitIdle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send(input string nm, input logic [15:0] x, input logic [15:0] exp, input bit push);
    exp_t e;
    waitIdle();
    in_data  = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (push) begin
      e.val  = exp;
      e.acc  = cyc;
      e.name = nm;
      expQ.push_back(e);
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {15'd0, in_ready}, 16'd1);
    chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_out_data", out_data, 16'h0000);
    chk("reset_cfg_err", {15'd0, cfg_err}, 16'd0);
    rst_n = 1'b1;
    tick();

    setCoefs(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    send("pass_through", 16'h0180, 16'h0180, 1'b1);

    doClear();
    setCoefs(16'h0180, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    send("scale_pos", 16'h0340, 16'h04E0, 1'b1);
    send("scale_neg", 16'h8340, 16'h84E0, 1'b1);

    doClear();
    setCoefs(16'h7F80, 16'h7F80, 16'h0000, 16'h0000, 16'h0000);
    send("sat_pos_1", 16'h7F40, 16'h7FFF, 1'b1);
    send("sat_pos_2", 16'h7F40, 16'h7FFF, 1'b1);
    send("sat_cancel", 16'hFF40, 16'h0000, 1'b1);
    send("sat_neg", 16'hFF40, 16'hFFFF, 1'b1);

    doClear();
    setCoefs(16'h0100, 16'h0000, 16'h0000, 16'h0080, 16'h0000);
    send("fb_0", 16'h0100, 16'h0100, 1'b1);
    send("fb_1", 16'h0000, 16'h8080, 1'b1);
    send("fb_2", 16'h0000, 16'h0040, 1'b1);
    send("fb_3", 16'h0000, 16'h8020, 1'b1);

    doClear();
    setCoefs(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    waitIdle();
    cfgCnt    = 0;
    out_ready = 1'b0;
    send("bp_hold", 16'h0200, 16'h0200, 1'b1);
    tick();
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'h7000;
    tick();
    coef_we = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_out_valid_seen", {15'd0, out_valid}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data_stable", out_data, 16'h0200);
      chk("bp_in_ready_low", {15'd0, in_ready}, 16'd0);
      chk("bp_valid_held", {15'd0, out_valid}, 16'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chkInt("cfg_err_pulses", cfgCnt, 1);
    send("bp_coef_kept", 16'h0300, 16'h0300, 1'b1);

    send("aborted", 16'h0100, 16'h0000, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_mid_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_mid_out_data", out_data, 16'h0000);
    chk("rst_mid_cfg_err", {15'd0, cfg_err}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    wrCoef(3'd1, 16'h0100);
    wrCoef(3'd2, 16'h0100);
    send("post_reset_zero", 16'h0100, 16'h0000, 1'b1);

    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chkInt("queue_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_biquad_sequencer.md
# iir_biquad_sequencer

Time-multiplexed controller for one second-order IIR section built around a single shared sign-magnitude fixed-point multiplier. Accepts one input sample per handshake and sequences the five products b0·x[n], b1·x[n-1], b2·x[n-2], a1·y[n-1] and a2·y[n-2] through the multiplier, one per cycle. Accumulates the products with saturation and presents y[n] on an output handshake. Holds the coefficient bank and the filter history. It sits between the sample source and the next filter stage in the mixed IIR chain.

## Interface
Parameters:
- `W`, 16: sample/coefficient width; sign-magnitude, bit W-1 = sign, bits W-2:0 = magnitude.
- `FRAC`, 8: fractional bits of the magnitude (Q7.8 at defaults).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in W: input sample x[n].
- `in_valid` in 1: source offers `in_data`.
- `in_ready` out 1: sequencer can accept a sample.
- `out_data` out W: filter output y[n].
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: sink accepts `out_data`.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in 3: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 reserved.
- `coef_data` in W: coefficient value, same format as samples.
- `clear` in 1: zero the history registers.
- `cfg_err` out 1: one-cycle pulse when a write or clear is dropped.

## Operation
- Transfer function: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].
  - The a-products are negated by inverting the sign bit of the product.
- Multiply rule:
  - Product magnitude = (|A|·|B|) >> FRAC, truncated.
  - Product sign = sign(A) XOR sign(B).
  - Magnitude above 2^(W-1)−1 saturates to 0x7FFF / 0xFFFF.
- Accumulate rule:
  - Sign-magnitude add.
  - Saturate after every tap to ±(2^(W-1)−1).
  - A zero result is always encoded +0 (0x0000); 0x8000 on any input is treated as zero.
- FSM states:
  - IDLE: `in_ready`=1. Handshake latches x[n], clears acc → MAC.
  - MAC: tap counter 0..4, one product accumulated per cycle. After tap 4 → OUT.
  - OUT: `out_valid`=1, `out_data`=acc (stable). On `out_ready`: x2←x1, x1←x, y2←y1, y1←acc → IDLE.
- Config rules:
  - `coef_we` and `clear` are honoured only in IDLE.
  - In any other state they are dropped and `cfg_err` pulses the following cycle.
  - Reserved addresses are ignored without error.
  - `clear` zeroes x1, x2, y1, y2; coefficients are retained.
- Simultaneous events in IDLE:
  - `coef_we` together with an input handshake: the write lands first, so the new coefficient applies to that sample.
  - `clear` together with an input handshake: the sample uses zeroed history.
- Reset values:
  - State IDLE; `in_ready`=1; `out_valid`=0; `out_data`=0; `cfg_err`=0.
  - All coefficients and history = 0.
- Reset mid-operation aborts the sample without output and restores all reset values.

## Timing
- Input handshake at edge E0.
  - Taps accumulate at E1..E5.
  - `out_valid` is high from the cycle after E5.
  - Latency: 5 cycles from acceptance to `out_valid`.
- `in_ready` = (state==IDLE), decoded from the registered state; `out_valid` = (state==OUT).
- Minimum period is 7 cycles per sample: accept, 5 MAC cycles, 1 OUT cycle with `out_ready`=1.
- While `out_ready`=0: `out_data` is held, history is unchanged and `in_ready` stays 0.
- Multiplier and adder are combinational within one MAC cycle; acc is registered.

## Structure
- Package `iir_pkg`:
  - sample typedef (W-bit sign-magnitude), FRAC, saturation constants SAT_POS/SAT_NEG.
  - tap enum (TAP_B0..TAP_A2), FSM state enum.
  - sign-magnitude saturating add function `sm_add`.
- Sub-module: one instance of the existing `multiply` (parameter W-1).
  - Operands are muxed by the tap counter from the coefficient and history registers.
- No other sub-modules; the FSM, coefficient bank and history registers live in this block.

## Test plan
- Pass-through:
  - Setup: b0=0x0100, others 0.
  - Stimulus: x=0x0180.
  - Required: `out_data`=0x0180 exactly 5 cycles after acceptance.
- Scaling:
  - Setup: b0=0x0180, others 0.
  - Stimulus: x=0x0340, then x=0x8340.
  - Required: outputs 0x04E0, then 0x84E0.
- Saturation:
  - Setup: b0=0x7F80, b1=0x7F80.
  - Stimulus: x=0x7F40 twice.
  - Required: both outputs 0x7FFF, no wrap.
- Feedback:
  - Setup: b0=0x0100, a1=0x0080.
  - Stimulus: impulse 0x0100, then 0x0000 ×3.
  - Required: outputs 0x0100, 0x8080, 0x0040, 0x8020.
- Backpressure and config:
  - Stimulus: hold `out_ready`=0 for 4 cycles, and issue `coef_we` during MAC.
  - Required: `out_data` stable and `in_ready`=0 throughout; `cfg_err` pulses once; the coefficient is unchanged.
- Reset mid-MAC:
  - Stimulus: assert `rst_n`=0 at tap 2.
  - Required: `out_valid`=0, `in_ready`=1, coefficients and history zero; the next impulse with b0=0 yields 0x0000.
